// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory responder.
//                Holds the FSM state encoding, the latched request record
//                and the wait-state limit.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // Largest supported wait-state count; sets the wait counter width.
    localparam int unsigned MAX_WAIT = 15;
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Request captured on acceptance. The range flag is decoded once at
    // capture so later cycles never depend on the live bus.
    typedef struct packed {
        logic [31:0] adr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        inrange;
    } dmem_req_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Word-organised storage with a byte-enabled synchronous
//                write port and an asynchronous read port sharing a single
//                word address. Contents are not reset.
//  Ports       : clk     - write clock
//                we_i    - write strobe (word level)
//                be_i    - per-byte lane enables, lane i = bits 8i+7:8i
//                addr_i  - word index for both read and write
//                wdata_i - lane-aligned write data
//                rdata_o - combinational read of addr_i
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter string       INIT_FILE   = "",
    localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] r_mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    r_mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = r_mem_q[addr_i];

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data-memory responder for the IEU load/store interface.
//                Adds WAIT_CYCLES wait states per access, flags accesses
//                outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) with MemErr
//                and raises Stall while a request is outstanding.
//  Ports       : clk         - clock, rising edge
//                reset       - asynchronous reset, active low
//                MemEn       - request, held until MemReady
//                IEUAdr      - byte address, bits [1:0] ignored
//                WriteByteEn - lane write enables, 4'b0000 = read
//                WriteData   - lane-aligned store data
//                ReadData    - full load word
//                MemReady    - one-cycle completion pulse
//                MemErr      - out-of-range flag, valid with MemReady
//                Stall       - MemEn & ~MemReady
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemEn,
    input  logic [31:0] IEUAdr,
    input  logic [3:0]  WriteByteEn,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr,
    output logic        Stall
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_SPAN = 33'(DEPTH_WORDS) << 2;

    // ------------------------------------------------------------------
    // Live-bus decode. The subtraction wraps, so addresses below
    // BASE_ADDR become huge offsets and fall out of range naturally.
    // ------------------------------------------------------------------
    logic [31:0]   w_in_ofs;
    logic          w_in_range;
    logic [AW-1:0] w_in_idx;

    assign w_in_ofs   = IEUAdr - BASE_ADDR;
    assign w_in_range = ({1'b0, w_in_ofs} < c_SPAN);
    assign w_in_idx   = w_in_ofs[AW+1:2];

    // Storage port
    logic          w_arr_we;
    logic [3:0]    w_arr_be;
    logic [AW-1:0] w_arr_addr;
    logic [31:0]   w_arr_wdata;
    logic [31:0]   w_arr_rdata;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .we_i    (w_arr_we),
        .be_i    (w_arr_be),
        .addr_i  (w_arr_addr),
        .wdata_i (w_arr_wdata),
        .rdata_o (w_arr_rdata)
    );

    generate
        if (WAIT_CYCLES == 0) begin : g_comb
            // Zero-wait: every request completes in the cycle it is made.
            // Outputs are held quiet while reset is asserted.
            assign w_arr_we    = MemEn & (|WriteByteEn) & w_in_range & reset;
            assign w_arr_be    = WriteByteEn;
            assign w_arr_addr  = w_in_idx;
            assign w_arr_wdata = WriteData;

            assign MemReady = MemEn & reset;
            assign MemErr   = MemEn & reset & ~w_in_range;
            assign ReadData = (reset & w_in_range) ? w_arr_rdata : 32'h0;
            assign Stall    = MemEn & ~MemReady;
        end else begin : g_fsm
            // The acceptance cycle counts as the first wait state, so the
            // counter holds the wait cycles still to come after acceptance.
            localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(WAIT_CYCLES - 1);

            dmem_state_t      r_state_q, w_state_d;
            logic [CNT_W-1:0] r_cnt_q, w_cnt_d;
            dmem_req_t        r_req_q, w_req_d;
            logic [31:0]      r_rdata_q, w_rdata_d;
            logic             w_fire;
            dmem_req_t        w_in_req;
            dmem_req_t        w_acc_req;

            assign w_in_req = '{adr: IEUAdr, be: WriteByteEn,
                                wdata: WriteData, inrange: w_in_range};

            // In IDLE the access can fire on the acceptance edge (one wait
            // state), so the live request feeds the array; later states use
            // the latched copy and ignore bus changes.
            assign w_acc_req = (r_state_q == IDLE) ? w_in_req : r_req_q;

            // State register
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state_q <= IDLE;
                    r_cnt_q   <= '0;
                    r_req_q   <= '0;
                    r_rdata_q <= 32'h0;
                end else begin
                    r_state_q <= w_state_d;
                    r_cnt_q   <= w_cnt_d;
                    r_req_q   <= w_req_d;
                    r_rdata_q <= w_rdata_d;
                end
            end

            // Next-state logic
            always_comb begin
                w_state_d = r_state_q;
                w_cnt_d   = r_cnt_q;
                w_req_d   = r_req_q;
                w_fire    = 1'b0;
                case (r_state_q)
                    IDLE: begin
                        if (MemEn) begin
                            w_req_d = w_in_req;
                            w_cnt_d = c_LOAD;
                            if (c_LOAD == '0) begin
                                w_state_d = DONE;
                                w_fire    = 1'b1;
                            end else begin
                                w_state_d = WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (!MemEn) begin
                            // Abort: nothing is written, ReadData is kept.
                            w_state_d = IDLE;
                        end else begin
                            w_cnt_d = r_cnt_q - 1'b1;
                            if (w_cnt_d == '0) begin
                                w_state_d = DONE;
                                w_fire    = 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        w_state_d = IDLE;
                    end
                    default: begin
                        w_state_d = IDLE;
                    end
                endcase
            end

            // Load data is captured on the edge entering DONE so it is
            // visible alongside MemReady; writes never touch ReadData.
            always_comb begin
                w_rdata_d = r_rdata_q;
                if (w_fire && (w_acc_req.be == 4'b0000)) begin
                    w_rdata_d = w_acc_req.inrange ? w_arr_rdata : 32'h0;
                end
            end

            // The store commits on the edge leaving DONE rather than the
            // edge entering it, so a reset arriving during the MemReady
            // cycle still cancels the write. The reset level gate covers
            // the edge at which reset is already low.
            assign w_arr_we    = (r_state_q == DONE) & (|r_req_q.be) &
                                 r_req_q.inrange & reset;
            assign w_arr_be    = r_req_q.be;
            assign w_arr_wdata = r_req_q.wdata;
            assign w_arr_addr  = AW'((w_acc_req.adr - BASE_ADDR) >> 2);

            // Output logic
            always_comb begin
                MemReady = (r_state_q == DONE);
                MemErr   = (r_state_q == DONE) & ~r_req_q.inrange;
                ReadData = r_rdata_q;
                Stall    = MemEn & ~MemReady;
            end
        end
    endgenerate

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Scoreboard bench for dmem_responder. Instance A uses two
//                wait states over 1024 words; instance B uses zero wait
//                states over 16 words. Drivers queue expected responses and
//                per-instance monitors compare on every MemReady.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        chk;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        a_en, b_en;
    logic [31:0] a_adr, b_adr, a_wd, b_wd, a_rd, b_rd;
    logic [3:0]  a_be, b_be;
    logic        a_rdy, a_err, a_stall, b_rdy, b_err, b_stall;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_2000),
        .WAIT_CYCLES (2),
        .INIT_FILE   ("")
    ) u_dut_a (
        .clk (clk), .reset (reset), .MemEn (a_en), .IEUAdr (a_adr),
        .WriteByteEn (a_be), .WriteData (a_wd), .ReadData (a_rd),
        .MemReady (a_rdy), .MemErr (a_err), .Stall (a_stall)
    );

    dmem_responder #(
        .DEPTH_WORDS (16),
        .BASE_ADDR   (32'h0000_2000),
        .WAIT_CYCLES (0),
        .INIT_FILE   ("")
    ) u_dut_b (
        .clk (clk), .reset (reset), .MemEn (b_en), .IEUAdr (b_adr),
        .WriteByteEn (b_be), .WriteData (b_wd), .ReadData (b_rd),
        .MemReady (b_rdy), .MemErr (b_err), .Stall (b_stall)
    );

    int   n_vec = 0;
    int   n_mis = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (reset === 1'b1 && a_rdy === 1'b1) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_ready", 32'(a_rdy), 32'd0);
            end else begin
                exp_t e;
                e = exp_a.pop_front();
                check("a_err", 32'(a_err), 32'(e.err));
                if (e.chk) check("a_rdata", a_rd, e.rd);
            end
        end
        if (reset === 1'b1 && a_rdy === 1'b0 && a_err !== 1'b0)
            check("a_err_without_ready", 32'(a_err), 32'd0);
    end

    always @(negedge clk) begin
        if (reset === 1'b1 && b_rdy === 1'b1) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_ready", 32'(b_rdy), 32'd0);
            end else begin
                exp_t e;
                e = exp_b.pop_front();
                check("b_err", 32'(b_err), 32'(e.err));
                if (e.chk) check("b_rdata", b_rd, e.rd);
            end
        end
    end

    // ---------------- instance A access ----------------
    // Called just after a rising edge. Expects MemReady two cycles after
    // acceptance and Stall high for exactly those two cycles.
    task automatic a_access(input logic [31:0] adr, input logic [3:0] be,
                            input logic [31:0] wd, input logic [31:0] erd,
                            input logic eerr, input string tag);
        int lat = 0;
        int stl = 0;
        bit done = 1'b0;
        exp_a.push_back('{rd: erd, err: eerr, chk: 1'b1});
        a_en = 1'b1; a_adr = adr; a_be = be; a_wd = wd;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (a_stall) stl++;
            if (a_rdy) done = 1'b1;
            else lat++;
        end
        @(posedge clk); #1;
        a_en = 1'b0; a_be = 4'h0;
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_stall_cycles"}, 32'(stl), 32'd2);
        @(posedge clk); #1;
    endtask

    // ---------------- instance B table ----------------
    localparam int NB = 4;
    logic [31:0] tb_adr [NB] = '{32'h2010, 32'h2010, 32'h2010, 32'h2040};
    logic [3:0]  tb_be  [NB] = '{4'h0, 4'hF, 4'h0, 4'h0};
    logic [31:0] tb_wd  [NB] = '{32'h0, 32'h1357_9BDF, 32'h0, 32'h0};
    logic [31:0] tb_erd [NB] = '{32'h0, 32'h0, 32'h1357_9BDF, 32'h0};
    logic        tb_err [NB] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        tb_chk [NB] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int rdy_cnt;
        bit seen;
        reset = 1'b0;
        a_en = 1'b0; a_adr = 32'h0; a_be = 4'h0; a_wd = 32'h0;
        b_en = 1'b0; b_adr = 32'h0; b_be = 4'h0; b_wd = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_ready", 32'(a_rdy), 32'd0);
        check("rst_a_err", 32'(a_err), 32'd0);
        check("rst_a_rdata", a_rd, 32'h0);
        check("rst_a_stall", 32'(a_stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Full write, read back, byte merge
        a_access(32'h2004, 4'hF, 32'hDEAD_BEEF, 32'h0,        1'b0, "wr_full");
        a_access(32'h2004, 4'h0, 32'h0,        32'hDEAD_BEEF, 1'b0, "rd_full");
        a_access(32'h2004, 4'b0010, 32'h0000_AA00, 32'hDEAD_BEEF, 1'b0, "wr_byte");
        a_access(32'h2004, 4'h0, 32'h0,        32'hDEAD_AAEF, 1'b0, "rd_merge");

        // Sentinels at the words an address-wrap bug would hit
        a_access(32'h2000, 4'hF, 32'h1111_1111, 32'hDEAD_AAEF, 1'b0, "wr_w0");
        a_access(32'h2FFC, 4'hF, 32'h2222_2222, 32'hDEAD_AAEF, 1'b0, "wr_wlast");

        // Out of range below and just above
        a_access(32'h1FFC, 4'h0, 32'h0,         32'h0, 1'b1, "rd_below");
        a_access(32'h3000, 4'h0, 32'h0,         32'h0, 1'b1, "rd_above");
        a_access(32'h1FFC, 4'hF, 32'hBAD0_BAD0, 32'h0, 1'b1, "wr_below");
        a_access(32'h3000, 4'hF, 32'hBAD1_BAD1, 32'h0, 1'b1, "wr_above");
        a_access(32'h2000, 4'h0, 32'h0, 32'h1111_1111, 1'b0, "rd_w0");
        a_access(32'h2FFC, 4'h0, 32'h0, 32'h2222_2222, 1'b0, "rd_wlast");
        a_access(32'h2004, 4'h0, 32'h0, 32'hDEAD_AAEF, 1'b0, "rd_2004");

        // Known contents for the abort / reset cases
        a_access(32'h2008, 4'hF, 32'h0BAD_F00D, 32'hDEAD_AAEF, 1'b0, "wr_2008");
        a_access(32'h2008, 4'h0, 32'h0,         32'h0BAD_F00D, 1'b0, "rd_2008");

        // Abort: MemEn drops during the single WAIT cycle
        a_en = 1'b1; a_adr = 32'h2008; a_be = 4'hF; a_wd = 32'h1234_5678;
        rdy_cnt = 0;
        @(negedge clk); if (a_rdy) rdy_cnt++;
        @(posedge clk); #1;
        a_en = 1'b0; a_be = 4'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (a_rdy) rdy_cnt++;
        end
        check("abort_no_ready", 32'(rdy_cnt), 32'd0);
        check("abort_rdata_kept", a_rd, 32'h0BAD_F00D);
        @(posedge clk); #1;
        a_access(32'h2008, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0, "abort_readback");

        // Reset during WAIT of a write
        a_en = 1'b1; a_adr = 32'h2008; a_be = 4'hF; a_wd = 32'hCAFE_F00D;
        @(posedge clk); #2;
        reset = 1'b0; a_en = 1'b0; a_be = 4'h0;
        #1;
        check("rstwait_ready", 32'(a_rdy), 32'd0);
        check("rstwait_err", 32'(a_err), 32'd0);
        check("rstwait_rdata", a_rd, 32'h0);
        check("rstwait_stall", 32'(a_stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        a_access(32'h2008, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0, "rstwait_readback");

        // Reset during the DONE cycle of a write
        exp_a.push_back('{rd: 32'h0BAD_F00D, err: 1'b0, chk: 1'b1});
        a_en = 1'b1; a_adr = 32'h2008; a_be = 4'hF; a_wd = 32'h55AA_55AA;
        seen = 1'b0;
        for (int c = 0; c < 16 && !seen; c++) begin
            @(negedge clk);
            if (a_rdy) seen = 1'b1;
        end
        check("rstdone_reached", 32'(seen), 32'd1);
        #1;
        reset = 1'b0; a_en = 1'b0; a_be = 4'h0;
        #1;
        check("rstdone_ready", 32'(a_rdy), 32'd0);
        check("rstdone_rdata", a_rd, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        a_access(32'h2008, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0, "rstdone_readback");

        // Zero-wait instance: back-to-back with MemEn held high
        for (int i = 0; i < NB; i++) begin
            exp_b.push_back('{rd: tb_erd[i], err: tb_err[i], chk: tb_chk[i]});
            b_en = 1'b1; b_adr = tb_adr[i]; b_be = tb_be[i]; b_wd = tb_wd[i];
            @(negedge clk);
            check($sformatf("b_ready_%0d", i), 32'(b_rdy), 32'd1);
            check($sformatf("b_stall_%0d", i), 32'(b_stall), 32'd0);
            @(posedge clk); #1;
        end
        b_en = 1'b0; b_be = 4'h0;
        @(negedge clk);
        check("b_idle_stall", 32'(b_stall), 32'd0);

        repeat (3) @(posedge clk);
        check("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the IEU load/store interface (MemEn, IEUAdr, WriteData, WriteByteEn in; ReadData out).
- Holds a byte-enabled word array with a configurable wait-state count.
- Returns MemReady/MemErr and drives a Stall output so the core freezes its PC while an access is outstanding.
- Lets the sample processor run against slow memory instead of an ideal combinational array.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two; AW = log2(DEPTH_WORDS).
- BASE_ADDR, 32'h0000_2000, byte address of word 0.
- WAIT_CYCLES, 2, wait states per access; legal range 0..15.
- INIT_FILE, "", optional $readmemh image; empty means the array is not initialised.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous reset, active-low.
- MemEn  input  1  access request; initiator holds it high until MemReady.
- IEUAdr  input  32  byte address; bits [1:0] ignored.
- WriteByteEn  input  4  per-byte write enables; 4'b0000 means a read.
- WriteData  input  32  store data, already lane-aligned.
- ReadData  output  32  full load word; initiator performs byte/half extraction.
- MemReady  output  1  one-cycle completion pulse.
- MemErr  output  1  pulses with MemReady when the address is out of range.
- Stall  output  1  MemEn & ~MemReady.

Behaviour:
- Reset (reset low, async): state IDLE, wait counter 0, latched request cleared, ReadData 32'h0, MemReady 0, MemErr 0. Array contents are not reset.
- States: IDLE, WAIT, DONE.
- Address decode:
  - offset = IEUAdr - BASE_ADDR.
  - In range iff offset < 4*DEPTH_WORDS; word index = offset[AW+1:2].
  - Subtraction wraps mod 2^32, so addresses below BASE_ADDR are out of range.
- WAIT_CYCLES = 0 (no FSM):
  - MemReady = MemEn combinationally.
  - ReadData = array[index] combinationally.
  - Write commits at the clock edge ending the cycle.
- WAIT_CYCLES > 0:
  - IDLE & MemEn in cycle t: latch IEUAdr, WriteByteEn, WriteData and the range flag. Load counter = WAIT_CYCLES-1, go to WAIT.
  - WAIT: decrement each cycle. When counter is 0: go to DONE, perform the read into the ReadData register, commit the write with byte enables.
  - DONE (cycle t+WAIT_CYCLES): MemReady = 1 and MemErr = range error. Next state is IDLE.
  - MemReady therefore rises exactly WAIT_CYCLES cycles after acceptance.
  - A MemEn held high in the cycle after DONE is a new request, accepted in IDLE.
- Request capture: address, data and byte enables are taken from the latched copy. Input changes during WAIT are ignored.
- Abort: MemEn low while in WAIT returns the FSM to IDLE next cycle. No write, ReadData unchanged, no MemReady.
- Out-of-range: write dropped, ReadData set to 32'h0, MemErr = 1 for the MemReady cycle only.
- ReadData holds its value until the next completed read. A completed write does not change ReadData.
- Partial write: only lanes with WriteByteEn[i]=1 change (bits 8i+7:8i). Other bytes are preserved.
- Reset asserted mid-access: immediate return to IDLE. No write commits and MemReady stays low, even if reset is in the DONE cycle.
- Stall is combinational from MemEn and MemReady and is 0 whenever MemEn is 0.

Decomposition:
- Package dmem_pkg:
  - dmem_state_t enum {IDLE, WAIT, DONE}.
  - Request struct {adr, be, wdata, inrange}.
  - Localparam MAX_WAIT = 15.
- One sub-module dmem_array:
  - Synchronous write with 4 byte enables, asynchronous read port, DEPTH_WORDS/INIT_FILE parameters.
  - Responder FSM, counter and decode stay in dmem_responder.

Test Plan:
- WAIT_CYCLES=2, write 32'hDEADBEEF with WriteByteEn=4'hF at 32'h2004, then read 32'h2004 -> MemReady at t+2 for each access, ReadData=32'hDEADBEEF, Stall high for exactly 2 cycles per access.
- Byte merge: after the step above, write 32'h0000_AA00 with WriteByteEn=4'b0010, then read -> ReadData=32'hDEADAAEF.
- Out of range: read 32'h1FFC and 32'h2000+4*DEPTH_WORDS -> MemErr=1 with MemReady, ReadData=32'h0; a write to either address leaves every array word unchanged.
- Abort: MemEn drops after 1 WAIT cycle of a write of 32'h1234_5678 to 32'h2008 -> no MemReady; a subsequent read returns the prior contents of 32'h2008.
- Reset mid-access: reset low during WAIT of a write -> outputs 0 immediately, FSM in IDLE, write not committed; a read after release completes at t+2.
- WAIT_CYCLES=0 build: back-to-back read, write, read with MemEn held high -> MemReady=1 every cycle, Stall=0 throughout, read-after-write returns the new data.
